// File: rtl/led_scan_arbiter.sv
// Two-requester arbiter for an 8-digit multiplexed 7-segment display.
// The owner's 32-bit BCD frame is snapshotted and scanned digit 7 down to 0.
// A requester that is still asking can be preempted only after HOLD owned cycles.
module led_scan_arbiter #(
    parameter int TWKLE = 4,
    parameter int HOLD  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] frame0,
    input  logic [31:0] frame1,
    output logic [1:0]  gnt,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int PW = (TWKLE > 1) ? $clog2(TWKLE) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [PW-1:0] PH_LAST   = PW'(TWKLE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last_gnt;
    logic          grant;
    logic          grant_to;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] phase;
    logic [2:0]    idx;
    logic [31:0]   snap;
    logic [6:0]    seg;

    // {g,f,e,d,c,b,a}, active-low; non-BCD nibbles blank the digit
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state and grant decision: release, preemption after hold, tie-break
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_to  = 1'b0;
        case (state)
            IDLE: begin
                if (req == 2'b01) begin
                    grant = 1'b1; grant_to = 1'b0;
                end else if (req == 2'b10) begin
                    grant = 1'b1; grant_to = 1'b1;
                end else if (req == 2'b11) begin
                    grant = 1'b1; grant_to = ~last_gnt;
                end
            end
            OWN0: begin
                if (!req[0]) begin
                    if (req[1]) begin
                        grant = 1'b1; grant_to = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (req[1] && hold_cnt == HOLD_LAST) begin
                    grant = 1'b1; grant_to = 1'b1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    if (req[0]) begin
                        grant = 1'b1; grant_to = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (req[0] && hold_cnt == HOLD_LAST) begin
                    grant = 1'b1; grant_to = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant) begin
            state_nxt = grant_to ? OWN1 : OWN0;
        end
    end

    // FSM state and last-grant pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_gnt <= grant_to;
            end
        end
    end

    // Scan engine: a grant restarts the scan and takes priority over a digit wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap     <= '1;
            idx      <= 3'd7;
            phase    <= '0;
            hold_cnt <= '0;
        end else if (grant) begin
            snap     <= grant_to ? frame1 : frame0;
            idx      <= 3'd7;
            phase    <= '0;
            hold_cnt <= '0;
        end else if (state != IDLE) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (phase == PH_LAST) begin
                phase <= '0;
                if (idx == 3'd0) begin
                    idx  <= 3'd7;
                    snap <= (state == OWN1) ? frame1 : frame0;
                end else begin
                    idx <= idx - 3'd1;
                end
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Registered display drive, blank whenever nobody owns the display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en <= '1;
            seg    <= '1;
        end else if (state == IDLE) begin
            led_en <= '1;
            seg    <= '1;
        end else begin
            led_en <= ~(8'd1 << idx);
            seg    <= decode(snap[idx*4 +: 4]);
        end
    end

    assign gnt    = (state == OWN0) ? 2'b01 : (state == OWN1) ? 2'b10 : 2'b00;
    assign led_ca = seg[0];
    assign led_cb = seg[1];
    assign led_cc = seg[2];
    assign led_cd = seg[3];
    assign led_ce = seg[4];
    assign led_cf = seg[5];
    assign led_cg = seg[6];
    assign led_dp = 1'b1;

endmodule

// File: tb/tb_led_scan_arbiter.sv
// Directed bench for led_scan_arbiter: scan pattern, release, preemption, reset.
module tb_led_scan_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] frame0;
    logic [31:0] frame1;
    logic [1:0]  gnt;
    logic [7:0]  led_en;
    logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected segment words per digit, {d7,d6,...,d0}, each {g,f,e,d,c,b,a}
    localparam logic [55:0] SEG_12000128 = {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h00};
    localparam logic [55:0] SEG_98765432 = {7'h18, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24};
    localparam logic [55:0] SEG_34567890 = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18, 7'h40};
    localparam logic [55:0] SEG_BLANK10  = {7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h79, 7'h40};

    led_scan_arbiter #(.TWKLE(4), .HOLD(64)) dut (
        .clk(clk), .rst(rst), .req(req), .frame0(frame0), .frame1(frame1),
        .gnt(gnt), .led_en(led_en),
        .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
        .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_now();
        return {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
    endfunction

    // Check n consecutive negedges; position k selects digit 7-(k/4)%8
    task automatic scan(input string tag, input logic [55:0] segs, input int k0, input int n);
        int d;
        logic [7:0] en_exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = 7 - (((k0 + i) / 4) % 8);
            en_exp = ~(8'd1 << d);
            check({tag, "_en"}, {24'd0, led_en}, {24'd0, en_exp});
            check({tag, "_seg"}, {25'd0, seg_now()}, {25'd0, segs[d*7 +: 7]});
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; frame0 = '0; frame1 = '0;

        // Reset state
        @(negedge clk);
        check("rst_gnt", {30'd0, gnt}, 32'h0);
        check("rst_en", {24'd0, led_en}, 32'hff);
        check("rst_seg", {25'd0, seg_now()}, 32'h7f);
        check("rst_dp", {31'd0, led_dp}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_gnt", {30'd0, gnt}, 32'h0);

        // Single owner scan
        frame0 = 32'h1200_0128; req = 2'b01;
        @(negedge clk);
        check("own0_gnt", {30'd0, gnt}, 32'h1);
        check("own0_en_lag", {24'd0, led_en}, 32'hff);
        scan("single", SEG_12000128, 0, 64);

        // Release to idle
        req = 2'b00;
        @(negedge clk);
        check("rel_gnt", {30'd0, gnt}, 32'h0);
        @(negedge clk);
        check("rel_en", {24'd0, led_en}, 32'hff);
        check("rel_seg", {25'd0, seg_now()}, 32'h7f);

        // Blank nibbles
        frame0 = 32'hFFFF_FF10; req = 2'b01;
        @(negedge clk);
        check("blank_gnt", {30'd0, gnt}, 32'h1);
        scan("blank", SEG_BLANK10, 0, 32);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("blank_rel_en", {24'd0, led_en}, 32'hff);

        // Mid-scan frame change while digit 4 is showing
        frame0 = 32'h1200_0128; req = 2'b01;
        @(negedge clk);
        check("mid_gnt", {30'd0, gnt}, 32'h1);
        scan("mid_old", SEG_12000128, 0, 13);
        frame0 = 32'h9876_5432;
        scan("mid_old", SEG_12000128, 13, 19);
        scan("mid_new", SEG_98765432, 0, 32);

        // Owner drops with the other requesting: immediate switch
        frame1 = 32'h3456_7890; req = 2'b10;
        @(negedge clk);
        check("sw_gnt", {30'd0, gnt}, 32'h2);
        scan("sw_f1", SEG_34567890, 0, 32);

        // Tie after reset, then hold-based preemption both ways
        rst = 1'b1;
        @(negedge clk);
        check("rst2_gnt", {30'd0, gnt}, 32'h0);
        rst = 1'b0;
        frame0 = 32'h1200_0128; req = 2'b11;
        @(negedge clk);
        check("tie_gnt", {30'd0, gnt}, 32'h1);
        scan("tie_f0", SEG_12000128, 0, 63);
        check("hold0_gnt", {30'd0, gnt}, 32'h1);
        @(negedge clk);
        check("pre1_gnt", {30'd0, gnt}, 32'h2);
        scan("pre_f1", SEG_34567890, 0, 63);
        check("hold1_gnt", {30'd0, gnt}, 32'h2);
        @(negedge clk);
        check("pre0_gnt", {30'd0, gnt}, 32'h1);

        // Asynchronous reset between edges while owner 1 holds the display
        req = 2'b10;
        @(negedge clk);
        check("own1_gnt", {30'd0, gnt}, 32'h2);
        @(negedge clk);
        check("own1_en", {24'd0, led_en}, 32'h7f);
        #2 rst = 1'b1;
        #1;
        check("async_gnt", {30'd0, gnt}, 32'h0);
        check("async_en", {24'd0, led_en}, 32'hff);
        check("async_seg", {25'd0, seg_now()}, 32'h7f);
        #1 rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        check("post_rst_gnt", {30'd0, gnt}, 32'h1);
        @(negedge clk);
        check("post_rst_en", {24'd0, led_en}, 32'h7f);
        check("post_rst_seg", {25'd0, seg_now()}, 32'h79);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
